// File: rtl/gcd_pkg.sv
// Shared types and helpers for the round-robin GCD scheduler.
// Holds the FSM encoding, default widths and the next-grant search.
package gcd_pkg;

    localparam int GCD_W      = 32;
    localparam int GCD_CW     = 8;
    localparam int GCD_MAXREQ = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Returns {found, index}: first valid requester after 'last', wrapping at nreq.
    function automatic logic [3:0] rr_pick(
        input logic [GCD_MAXREQ-1:0] valid,
        input logic [2:0]            last,
        input int                    nreq
    );
        logic       found;
        logic [2:0] idx;
        int         cand;
        found = 1'b0;
        idx   = 3'd0;
        for (int i = 1; i <= GCD_MAXREQ; i++) begin
            cand = (int'(last) + i) % nreq;
            if (!found && (i <= nreq) && valid[cand[2:0]]) begin
                found = 1'b1;
                idx   = cand[2:0];
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/gcd_iter_core.sv
// Euclidean modulo datapath: one a%b step per i_step while b is nonzero.
// Load takes one cycle; no backpressure, the scheduler drives i_step only while b!=0.
module gcd_iter_core #(
    parameter int W  = 32,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [W-1:0]  i_a,
    input  logic [W-1:0]  i_b,
    input  logic          i_step,
    output logic [W-1:0]  o_a,
    output logic          o_zero_b,
    output logic [CW-1:0] o_cnt
);

    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [CW-1:0] r_cnt;
    logic          w_zero_b;
    logic [W-1:0]  w_rem;

    assign w_zero_b = (r_b == '0);
    // Divisor guarded so the modulo never sees a zero operand.
    assign w_rem    = w_zero_b ? '0 : (r_a % r_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_cnt <= '0;
        end else if (i_step && !w_zero_b) begin
            r_a <= r_b;
            r_b <= w_rem;
            if (r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_a      = r_a;
    assign o_zero_b = w_zero_b;
    assign o_cnt    = r_cnt;

endmodule

// File: rtl/gcd_rr_sched.sv
// Round-robin scheduler sharing one GCD datapath; result valid k+2 cycles after accept.
// Holds the response until rsp_ready; accepts no request while a job is in flight.
module gcd_rr_sched
    import gcd_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = GCD_W,
    parameter int IDW  = 2,
    parameter int CW   = GCD_CW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [IDW-1:0]  rsp_id,
    output logic [W-1:0]    rsp_gcd,
    output logic [CW-1:0]   rsp_iters,
    output logic            busy
);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [IDW-1:0] r_last;
    logic [IDW-1:0] r_id_q;
    logic [IDW-1:0] r_rsp_id;
    logic [W-1:0]   r_rsp_gcd;
    logic [CW-1:0]  r_rsp_iters;

    logic [3:0]     w_pick;
    logic           w_found;
    logic [2:0]     w_grant;
    logic [IDW-1:0] w_gid;
    logic [W-1:0]   w_a_sel;
    logic [W-1:0]   w_b_sel;
    logic           w_load;
    logic           w_step;
    logic           w_fin;
    logic [W-1:0]   w_core_a;
    logic           w_zero_b;
    logic [CW-1:0]  w_cnt;

    assign w_pick  = rr_pick(GCD_MAXREQ'(req_valid), 3'(r_last), NREQ);
    assign w_found = w_pick[3];
    assign w_grant = w_pick[2:0];
    assign w_gid   = w_grant[IDW-1:0];

    always_comb begin
        w_a_sel = '0;
        w_b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gid == IDW'(i)) begin
                w_a_sel = req_a[i*W +: W];
                w_b_sel = req_b[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_fin       = 1'b0;
        req_ready   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    req_ready   = {{(NREQ-1){1'b0}}, 1'b1} << w_gid;
                    w_load      = 1'b1;
                    w_state_nxt = ST_ITER;
                end
            end
            ST_ITER: begin
                if (w_zero_b) begin
                    w_fin       = 1'b1;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_step = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Pointer starts at the top index so requester 0 wins first after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last      <= IDW'(NREQ - 1);
            r_id_q      <= '0;
            r_rsp_id    <= '0;
            r_rsp_gcd   <= '0;
            r_rsp_iters <= '0;
        end else begin
            if (w_load) begin
                r_last <= w_gid;
                r_id_q <= w_gid;
            end
            if (w_fin) begin
                r_rsp_id    <= r_id_q;
                r_rsp_gcd   <= w_core_a;
                r_rsp_iters <= w_cnt;
            end
        end
    end

    gcd_iter_core #(
        .W  (W),
        .CW (CW)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_a      (w_a_sel),
        .i_b      (w_b_sel),
        .i_step   (w_step),
        .o_a      (w_core_a),
        .o_zero_b (w_zero_b),
        .o_cnt    (w_cnt)
    );

    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_id    = r_rsp_id;
    assign rsp_gcd   = r_rsp_gcd;
    assign rsp_iters = r_rsp_iters;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_gcd_rr_sched.sv
// Randomized and directed bench for gcd_rr_sched with a queue-based scoreboard.
module tb_gcd_rr_sched;

    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int IDW  = 2;
    localparam int CW   = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_gcd;
    logic [CW-1:0]     rsp_iters;
    logic              busy;

    logic [1:0]        s_req_valid;
    logic [1:0]        s_req_ready;
    logic [2*W-1:0]    s_req_a;
    logic [2*W-1:0]    s_req_b;
    logic              s_rsp_valid;
    logic              s_rsp_ready;
    logic [0:0]        s_rsp_id;
    logic [W-1:0]      s_rsp_gcd;
    logic [3:0]        s_rsp_iters;
    logic              s_busy;

    always #5 clk = ~clk;

    gcd_rr_sched #(.NREQ(NREQ), .W(W), .IDW(IDW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_gcd(rsp_gcd), .rsp_iters(rsp_iters),
        .busy(busy)
    );

    gcd_rr_sched #(.NREQ(2), .W(W), .IDW(1), .CW(4)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .req_valid(s_req_valid), .req_ready(s_req_ready),
        .req_a(s_req_a), .req_b(s_req_b),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready),
        .rsp_id(s_rsp_id), .rsp_gcd(s_rsp_gcd), .rsp_iters(s_rsp_iters),
        .busy(s_busy)
    );

    typedef struct {
        int          id;
        logic [31:0] gcd;
        int          iters;
        int          due;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   m_last   = NREQ - 1;
    int   acc_count = 0;
    int   rsp_count = 0;
    int   last_acc_cyc = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Euclid by definition: count modulo steps until the divisor is zero.
    function automatic void ref_gcd(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] g, output int k);
        logic [31:0] x, y, t;
        x = a; y = b; k = 0;
        while (y != 0) begin
            t = x % y; x = y; y = t; k++;
        end
        g = x;
    endfunction

    function automatic int rr_model(input logic [NREQ-1:0] v, input int last);
        for (int n = 1; n <= NREQ; n++) begin
            int c;
            c = (last + n) % NREQ;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // Monitor: predicts grants from the round-robin rule, pushes expected results,
    // and compares whatever the DUT presents on the response channel.
    always @(negedge clk) begin : monitor
        int          g;
        int          k;
        logic [31:0] gv;
        exp_t        e;
        if (!rst_n) begin
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_gcd", rsp_gcd, 0);
            chk("rst_rsp_iters", rsp_iters, 0);
            chk("rst_busy", busy, 0);
            q.delete();
            m_last     = NREQ - 1;
            prev_valid = 1'b0;
        end else begin
            chk("busy", busy, (q.size() != 0));
            g = (q.size() == 0) ? rr_model(req_valid, m_last) : -1;
            chk("req_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
            if (g >= 0) begin
                ref_gcd(req_a[g*W +: W], req_b[g*W +: W], gv, k);
                e.id    = g;
                e.gcd   = gv;
                e.iters = (k > 255) ? 255 : k;
                e.due   = cyc + k + 2;
                q.push_back(e);
                m_last       = g;
                acc_count    = acc_count + 1;
                last_acc_cyc = cyc;
            end
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", rsp_valid, 0);
                end else begin
                    e = q[0];
                    if (!prev_valid) chk("latency", cyc, e.due);
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_gcd", rsp_gcd, e.gcd);
                    chk("rsp_iters", rsp_iters, e.iters);
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        rsp_count = rsp_count + 1;
                    end
                end
            end
            prev_valid = rsp_valid;
        end
    end

    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b);
        int n;
        bit ok;
        n  = acc_count;
        ok = 0;
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_valid[i]    = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            if (acc_count > n) begin ok = 1; break; end
        end
        #1 req_valid[i] = 1'b0;
        if (!ok) timeout("issue_accept");
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            if (rsp_count == acc_count && !rsp_valid) begin ok = 1; break; end
        end
        #1;
        if (!ok) timeout("drain");
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    logic [31:0] fa [4] = '{32'd12, 32'd35, 32'd17, 32'd100};
    logic [31:0] fb [4] = '{32'd8,  32'd14, 32'd5,  32'd75};

    initial begin
        int          n;
        int          t0;
        int          k;
        bit          ok;
        logic [31:0] gv;
        rst_n       = 1'b1;
        req_valid   = '0;
        req_a       = '0;
        req_b       = '0;
        rsp_ready   = 1'b1;
        s_req_valid = '0;
        s_req_a     = '0;
        s_req_b     = '0;
        s_rsp_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic job, then the zero-operand corner cases from one requester.
        issue(0, 32'd48, 32'd18);
        drain();
        issue(2, 32'd0, 32'd0);  drain();
        issue(2, 32'd0, 32'd7);  drain();
        issue(2, 32'd9, 32'd0);  drain();

        // Response stall with another requester waiting.
        rsp_ready = 1'b0;
        issue(0, 32'd100, 32'd75);
        req_a[1*W +: W] = 32'd35;
        req_b[1*W +: W] = 32'd14;
        req_valid[1]    = 1'b1;
        ok = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1; break; end
        end
        if (!ok) timeout("stall_rsp_valid");
        repeat (20) @(posedge clk);
        #1;
        n = acc_count;
        rsp_ready = 1'b1;
        ok = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            if (acc_count > n) begin ok = 1; break; end
        end
        #1 req_valid[1] = 1'b0;
        if (!ok) timeout("stall_release_accept");
        drain();

        // Reset in the middle of a long job; no response may appear.
        issue(3, 32'd2971215073, 32'd1836311903);
        t0 = last_acc_cyc;
        while (cyc < t0 + 10) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        chk("no_rsp_after_reset", rsp_count, acc_count - 1);
        rsp_count = acc_count;
        issue(0, 32'd48, 32'd18);
        drain();

        // Fairness: everyone valid continuously.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = fa[i];
            req_b[i*W +: W] = fb[i];
        end
        n = acc_count;
        req_valid = '1;
        ok = 0;
        for (int c = 0; c < 500; c++) begin
            @(posedge clk);
            if (acc_count >= n + 5) begin ok = 1; break; end
        end
        #1 req_valid = '0;
        if (!ok) timeout("fair_accepts");
        drain();

        // Randomized traffic: toggling valids, changing operands, random backpressure.
        for (int c = 0; c < 3000; c++) begin
            req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                case ($urandom_range(0, 3))
                    0: req_a[i*W +: W] = 32'd0;
                    1: req_a[i*W +: W] = $urandom;
                    default: req_a[i*W +: W] = $urandom_range(0, 1000);
                endcase
                case ($urandom_range(0, 3))
                    0: req_b[i*W +: W] = 32'd0;
                    1: req_b[i*W +: W] = $urandom;
                    default: req_b[i*W +: W] = $urandom_range(0, 1000);
                endcase
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        drain();
        chk("rsp_count", rsp_count, acc_count);

        // Iteration counter saturation on a narrow-counter instance.
        s_req_a[W-1:0] = 32'd2971215073;
        s_req_b[W-1:0] = 32'd1836311903;
        s_req_valid    = 2'b01;
        ok = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (s_req_ready[0]) begin ok = 1; break; end
        end
        @(posedge clk);
        #1 s_req_valid = 2'b00;
        if (!ok) timeout("sat_accept");
        ok = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (s_rsp_valid) begin ok = 1; break; end
        end
        if (!ok) timeout("sat_rsp");
        ref_gcd(32'd2971215073, 32'd1836311903, gv, k);
        chk("sat_gcd", s_rsp_gcd, gv);
        chk("sat_iters", s_rsp_iters, (k > 15) ? 15 : k);
        chk("sat_id", s_rsp_id, 0);

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/gcd_rr_sched.md
Name: gcd_rr_sched

Overview:
Round-robin scheduler that shares one sequential Euclidean GCD datapath among NREQ requesters (e.g. Wishbone-side and LA-side clients of the user project).
- Each requester offers an operand pair on a valid/ready handshake.
- The scheduler grants one requester, sequences the modulo-iteration datapath to completion, and returns the result on a single tagged response channel.
- The block sits between the requester interfaces and the GCD datapath and owns all datapath sequencing.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 32, operand and result width in bits
IDW, 2, requester ID width; must equal clog2(NREQ) (minimum 1)
CW, 8, width of the per-job iteration counter

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  NREQ  per-requester operand-pair valid
req_ready  output  NREQ  per-requester accept; one-hot or zero
req_a  input  NREQ*W  operand A; requester i occupies bits [i*W +: W]
req_b  input  NREQ*W  operand B; same packing as req_a
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts result
rsp_id  output  IDW  index of the requester that owns the result
rsp_gcd  output  W  gcd(A,B)
rsp_iters  output  CW  modulo iterations used by this job; saturates at all-ones
busy  output  1  high in any state other than IDLE

Behaviour:
- States: IDLE, ITER, RESP.
- Reset (async, rst_n low) applies in any state, including mid-job:
  - state=IDLE; the in-flight job is dropped and no response is issued.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_gcd=0, rsp_iters=0, busy=0.
  - Round-robin pointer last_grant=NREQ-1, so requester 0 has top priority after reset.
- IDLE:
  - Combinational grant g = first i with req_valid[i]=1, scanning from last_grant+1 modulo NREQ.
  - req_ready[g]=1 only in IDLE and only for g; all other bits 0. No ready without a valid request.
  - On handshake at cycle T: a_q<=req_a[g], b_q<=req_b[g], id_q<=g, last_grant<=g, cnt<=0, state<=ITER.
- ITER, evaluated each cycle:
  - If b_q!=0: a_q<=b_q, b_q<=a_q % b_q, cnt<=cnt+1 (saturating).
  - If b_q==0: rsp_gcd<=a_q, rsp_id<=id_q, rsp_iters<=cnt, state<=RESP.
- Latency: a job needing k modulo steps has rsp_valid high from cycle T+k+2.
- RESP:
  - rsp_valid=1; rsp_id, rsp_gcd and rsp_iters are held stable until rsp_ready=1.
  - On rsp_valid&&rsp_ready: state<=IDLE; rsp_valid drops the next cycle.
  - Back-to-back jobs: minimum gap of one IDLE cycle between a response accept and the next request accept.
- Operand edge cases:
  - gcd(A,0)=A with k=0.
  - gcd(0,B)=B with k=1.
  - gcd(0,0)=0 with k=0.
  - The modulo operator is never evaluated with b_q==0.
- Requester rules:
  - req_valid may deassert before acceptance; no grant state is retained.
  - Operands are sampled only at handshake; requesters may change them freely afterwards.
- Fairness: with all requesters valid continuously, grant order is 0,1,2,3,0,...
- rsp_ready held low stalls the block in RESP indefinitely; no further requests are accepted meanwhile.

Decomposition:
- Package gcd_pkg:
  - state encoding constants ST_IDLE, ST_ITER, ST_RESP.
  - default widths GCD_W=32, GCD_CW=8.
  - function for round-robin next-grant index.
- Sub-module gcd_iter_core:
  - contains a_q, b_q, the modulo datapath and the iteration counter.
  - inputs: load, a_in, b_in, step. Outputs: a_q, zero_b, cnt.
  - the scheduler FSM, arbiter and response registers stay in gcd_rr_sched.

Test Plan:
- Req0 offers (48,18), rsp_ready=1 → rsp_id=0, rsp_gcd=6, rsp_iters=3, rsp_valid at T+5.
- Req2 offers (0,0), then (0,7), then (9,0) → gcd 0/k=0, gcd 7/k=1, gcd 9/k=0. req_ready[2] is the only ready bit asserted.
- All four requesters valid continuously with operands (12,8),(35,14),(17,5),(100,75) → responses in id order 0,1,2,3,0 with gcds 4,7,1,25,4.
- Response stall: hold rsp_ready=0 for 20 cycles while req1 is valid → rsp fields stable, req_ready=0 throughout, busy=1; release → req1 is accepted 2 cycles later.
- Reset mid-ITER on (2971215073,1836311903) (Fibonacci worst case, k=45): assert rst_n low at T+10 → all outputs zero, no response; the next job (48,18) completes normally with grant to requester 0.
- Saturation with CW=4, operands (2971215073,1836311903) → rsp_gcd=1, rsp_iters=15.
